// File: rtl/axi_arb_defs.sv
// rtl/axi_arb_defs.sv - shared state encoding and index-width helper for the bus arbiter
package axi_arb_defs;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int log2(input int n);
    for (int r = 1; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/priencr.sv
// rtl/priencr.sv - priority encoder, highest set index wins; input padded to a power of two
module priencr
  import axi_arb_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int IDXW  = log2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             any_o
);

  localparam int PW = 1 << IDXW;

  logic [PW-1:0] padded;

  assign padded = PW'(req_i);
  assign any_o  = |padded;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < PW; i++) begin
      if (padded[i]) idx_o = i[IDXW-1:0];
    end
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner selection: masked encoder first, raw encoder as wrap fallback
module rr_pick
  import axi_arb_defs::*;
#(
  parameter int N_REQ = 4,
  parameter int IDXW  = log2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  last_idx_i,
  output logic [IDXW-1:0]  winner_o,
  output logic             any_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [IDXW-1:0]  idx_masked;
  logic [IDXW-1:0]  idx_raw;
  logic             any_masked;
  logic             any_raw;

  // Only masters below the last winner are eligible before wrapping to the top.
  for (genvar i = 0; i < N_REQ; i++) begin : g_mask
    assign mask[i] = (IDXW'(i) < last_idx_i);
  end

  assign masked = req_i & mask;

  priencr #(.WIDTH(N_REQ), .IDXW(IDXW)) u_enc_masked (
    .req_i (masked),
    .idx_o (idx_masked),
    .any_o (any_masked)
  );

  priencr #(.WIDTH(N_REQ), .IDXW(IDXW)) u_enc_raw (
    .req_i (req_i),
    .idx_o (idx_raw),
    .any_o (any_raw)
  );

  assign winner_o = any_masked ? idx_masked : idx_raw;
  assign any_o    = any_raw;

endmodule

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin AXI-Lite slave-port arbiter with held grant and watchdog reclaim
module rr_bus_arbiter
  import axi_arb_defs::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDXW    = log2(N_REQ),
  parameter int TIMEOUT = 256,
  parameter int CNTW    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic             release_pulse,
  output logic [N_REQ-1:0] grant,
  output logic [IDXW-1:0]  grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic [CNTW-1:0]  WD_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [CNTW-1:0]  wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pick_req;
  logic [IDXW-1:0]  winner;
  logic             pick_any;
  logic             wdog_hit;
  logic             owner_done;

  // The current owner is excluded, so a releasing master only wins again after an idle cycle.
  assign pick_req   = req & ~grant_q;
  assign wdog_hit   = (TIMEOUT != 0) && (state_q == OWN) && (wdog_q == WD_LAST);
  assign owner_done = release_pulse || ~|(req & grant_q);

  rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
    .req_i      (pick_req),
    .last_idx_i (last_q),
    .winner_o   (winner),
    .any_o      (pick_any)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          grant_d = ONE << winner;
          idx_d   = winner;
          last_d  = winner;
          wdog_d  = '0;
        end
      end
      OWN: begin
        if (wdog_hit || owner_done) begin
          timeout_d = wdog_hit;
          wdog_d    = '0;
          if (pick_any) begin
            grant_d = ONE << winner;
            idx_d   = winner;
            last_d  = winner;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (wdog_q != {CNTW{1'b1}}) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    grant       = grant_q;
    grant_idx   = idx_q;
    grant_valid = (state_q == OWN);
    timeout     = timeout_q;
  end

  a_grant_onehot: assert property (@(posedge CLK) disable iff (!RST) $onehot0(grant_q));
  a_idx_encodes:  assert property (@(posedge CLK) disable iff (!RST)
                                   (state_q == OWN) |-> (grant_q == (ONE << idx_q)));
  a_valid_grant:  assert property (@(posedge CLK) disable iff (!RST)
                                   (state_q == IDLE) |-> (grant_q == '0));

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - scoreboard bench for rr_bus_arbiter: directed plan plus random traffic
module tb_rr_bus_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TO  = 8;
  localparam int N5  = 5;
  localparam int IW5 = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           rel;
  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_valid;
  logic           timeout;

  logic [N5-1:0]  req5;
  logic           rel5;
  logic [N5-1:0]  grant5;
  logic [IW5-1:0] idx5;
  logic           valid5;
  logic           timeout5;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CNTW(16)) u_dut (
    .CLK           (clk),
    .RST           (rst_n),
    .req           (req),
    .release_pulse (rel),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid),
    .timeout       (timeout)
  );

  rr_bus_arbiter #(.N_REQ(N5), .TIMEOUT(0), .CNTW(16)) u_dut5 (
    .CLK           (clk),
    .RST           (rst_n),
    .req           (req5),
    .release_pulse (rel5),
    .grant         (grant5),
    .grant_idx     (idx5),
    .grant_valid   (valid5),
    .timeout       (timeout5)
  );

  typedef struct packed {
    logic [N-1:0]  g;
    logic [IW-1:0] idx;
    logic          v;
    logic          t;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_push;
  exp_t sb_pop;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk downward from last winner, wrapping, first requester wins.
  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + N - k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  bit           m_own;
  int           m_idx;
  int           m_last;
  int           m_wdog;
  bit           m_to;
  bit           m_hit;
  logic [N-1:0] m_rr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = 0; m_idx = 0; m_last = 0; m_wdog = 0; m_to = 0;
      sb_q.delete();
    end else begin
      if (!m_own) begin
        m_to = 0;
        if (req != '0) begin
          m_idx  = rr_next(req, m_last);
          m_last = m_idx;
          m_own  = 1;
          m_wdog = 0;
        end
      end else begin
        m_hit = (m_wdog == TO - 1);
        if (m_hit || rel || !req[m_idx]) begin
          m_to = m_hit;
          m_rr = req;
          m_rr[m_idx] = 1'b0;
          m_wdog = 0;
          if (m_rr != '0) begin
            m_idx  = rr_next(m_rr, m_last);
            m_last = m_idx;
          end else begin
            m_own = 0;
            m_idx = 0;
          end
        end else begin
          m_to = 0;
          m_wdog++;
        end
      end
      sb_push.g   = m_own ? (N'(1) << m_idx) : '0;
      sb_push.idx = IW'(m_idx);
      sb_push.v   = m_own;
      sb_push.t   = m_to;
      sb_q.push_back(sb_push);
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      sb_pop = sb_q.pop_front();
      check("sb_grant", grant, sb_pop.g);
      check("sb_idx", grant_idx, sb_pop.idx);
      check("sb_valid", grant_valid, sb_pop.v);
      check("sb_timeout", timeout, sb_pop.t);
      check("onehot", $onehot0(grant), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           exp_ord[6] = '{3, 2, 1, 0, 3, 2};
  int           wait_cnt[N];
  logic [N-1:0] prev_g;
  int           r;

  initial begin
    rst_n = 1'b0; req = '0; rel = 1'b0; req5 = '0; rel5 = 1'b0;
    repeat (2) tick();
    check("rst_grant", grant, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    req = 4'b0101; tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_idx", grant_idx, 2);
    check("t1_valid", grant_valid, 1);
    rel = 1'b1; req = 4'b0001; tick(); rel = 1'b0;
    check("t1_b2b_grant", grant, 4'b0001);
    check("t1_b2b_idx", grant_idx, 0);
    check("t1_b2b_valid", grant_valid, 1);
    req = '0; rel = 1'b1; tick(); rel = 1'b0;
    check("t1_idle", grant_valid, 0);

    req = 4'b1111; tick();
    for (int g = 0; g < 6; g++) begin
      check($sformatf("t2_order%0d", g), grant_idx, exp_ord[g]);
      check($sformatf("t2_valid%0d", g), grant_valid, 1);
      tick(); tick();
      rel = 1'b1; tick(); rel = 1'b0;
    end
    req = '0; rel = 1'b1; tick(); rel = 1'b0; tick();

    req5 = 5'b10000; tick();
    check("t3_idx", idx5, 4);
    check("t3_grant", grant5, 5'b10000);
    check("t3_valid", valid5, 1);
    req5 = '0; rel5 = 1'b1; tick(); rel5 = 1'b0;
    check("t3_idle", valid5, 0);
    check("t3_timeout", timeout5, 0);

    req = 4'b0010; tick();
    check("t4_grant", grant, 4'b0010);
    repeat (7) tick();
    check("t4_pre_to", timeout, 0);
    check("t4_pre_grant", grant, 4'b0010);
    tick();
    check("t4_to", timeout, 1);
    check("t4_revoke", grant, 0);
    tick();
    check("t4_to_clear", timeout, 0);
    check("t4_regrant", grant, 4'b0010);
    req = 4'b1010;
    repeat (7) tick();
    check("t4b_pre_to", timeout, 0);
    tick();
    check("t4b_to", timeout, 1);
    check("t4b_grant", grant, 4'b1000);
    check("t4b_idx", grant_idx, 3);
    req = '0; rel = 1'b1; tick(); rel = 1'b0; tick();

    req = 4'b0010; tick();
    check("t5_grant", grant, 4'b0010);
    req = '0; tick();
    check("t5_abandon", grant, 0);
    check("t5_abandon_v", grant_valid, 0);
    req = 4'b0010; tick();
    check("t5_own", grant_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_grant", grant, 0);
    check("t5_async_valid", grant_valid, 0);
    check("t5_async_idx", grant_idx, 0);
    check("t5_async_to", timeout, 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();

    prev_g = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      if (grant != '0 && grant != prev_g) begin
        for (int i = 0; i < N; i++) begin
          if (grant[i]) begin
            check($sformatf("starve%0d", i), (wait_cnt[i] <= N), 1);
            wait_cnt[i] = 0;
          end else if (req[i]) begin
            wait_cnt[i]++;
          end
        end
      end
      prev_g = grant;
      rel = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          r = $urandom_range(0, 5);
          if (r < 2) begin
            rel = 1'b1;
            if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          end else if (r == 2 && $urandom_range(0, 7) == 0) begin
            req[i] = 1'b0;
          end
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
    req = '0; rel = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Lite slave port of the mriscv_axi interconnect between N_REQ masters.
- Arbitration uses two instances of the existing priority encoder (priencr): one on masked requests, one on raw requests.
- Grant is registered and held for a whole transaction until release.
- A watchdog forcibly reclaims the bus from a master that never releases.

Parameters:
- N_REQ, 4, number of requesters; legal range is 2 to 64; non-power-of-two values are legal.
- IDXW, log2(N_REQ) rounded up (same log2 function as priencr), width of the grant index.
- TIMEOUT, 256, maximum cycles a grant may be held. 0 disables the watchdog.
- CNTW, 16, watchdog counter width. TIMEOUT must be less than 2^CNTW.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-master request level; held high until the master is granted and finishes.
- release  input  1  single-cycle pulse from the granted master marking end of transaction.
- grant  output  N_REQ  one-hot grant; all zero when idle.
- grant_idx  output  IDXW  binary index of the granted master; valid when grant_valid=1.
- grant_valid  output  1  high while the bus is owned.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (RST=0, asynchronous):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE, last_idx=0, wdog=0.
- Priority function:
  - mask[i] = (i < last_idx).
  - masked = req & mask.
  - If |masked, winner = highest set index of masked; otherwise winner = highest set index of req.
  - Both encoders are priencr instances, so highest index wins.
  - Effect: after master k is served, masters below k are served next, then wrap to the top.
- States: IDLE, OWN.
- IDLE:
  - If |req, the next edge gives grant=onehot(winner), grant_idx=winner, grant_valid=1, last_idx=winner, wdog=0, state OWN.
  - Latency from req rising to grant is exactly 1 cycle.
  - If no request, stay in IDLE with outputs zero.
- OWN, evaluated in priority order at each edge:
  1. Watchdog: TIMEOUT!=0 and wdog==TIMEOUT-1.
     - Revoke the grant; timeout=1 for that cycle.
     - Re-arbitrate as in the release case below.
     - The offending master remains eligible but is now lowest priority via last_idx.
  2. release=1, or req[grant_idx]=0 (master abandoned).
     - If another request is pending, re-arbitrate with the current last_idx and grant the new winner on the same edge (back-to-back, no dead cycle). Stay in OWN, wdog=0.
     - Otherwise go to IDLE with grant=0 and grant_valid=0.
  3. Else hold grant, wdog=wdog+1. wdog saturates at its maximum and never wraps.
- Re-arbitration must exclude the master just released:
  - Compute with req' = req & ~grant.
  - A master that asserts release while still holding req is not re-granted immediately unless it is the only requester.
  - If it is the only requester, it is re-granted on the next edge.
- release while IDLE is ignored.
- Requests arriving or dropping while in OWN do not affect the current grant.
- grant is always one-hot or zero. grant_idx always equals the encoded grant.
- timeout is high for exactly one cycle per revocation.
- Asserting RST mid-transaction clears everything immediately, without waiting for a clock.

Decomposition:
- Shared package / include (axi_arb_defs):
  - State encodings IDLE=1'b0, OWN=1'b1.
  - The log2 function, identical to the one in priencr.
- Sub-module rr_pick (combinational):
  - Inputs req', last_idx.
  - Outputs winner and any; contains the two priencr instances and the mask logic.
- The top-level module holds the FSM, watchdog and output registers.

Test Plan:
1. Reset then req=4'b0101 → grant=4'b0100, grant_idx=2 one cycle later. Then release → grant=4'b0001, idx=0 on the next edge, with no idle cycle.
2. All four requesting continuously, release every 3 cycles → grant order 3,2,1,0,3,2 (round-robin wrap).
3. N_REQ=5, req=5'b10000 → grant_idx=4; checks the non-power-of-two padding path.
4. TIMEOUT=8, req=4'b0010 with no release → timeout pulses on cycle 8 of ownership and grant drops. req=4'b1010 instead → grant moves to 3 on the same edge as the timeout.
5. Granted master 1 drops req without release → grant clears the next cycle. RST pulsed low mid-OWN → all outputs go to 0 asynchronously.
6. Random req/release for 10k cycles; checker asserts:
   - grant is one-hot or zero.
   - No master waits more than N_REQ grants when every transaction length is at most TIMEOUT.
